// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and state type for the FFT sequencing controller.
//   FFT_N_POINTS / FFT_LOG2N : default transform length and stage count
//   STAGE_W                  : width of the stage index sent to address_generator
//   fft_state_t              : controller state encoding
package fft_pkg;

    localparam int FFT_N_POINTS = 1024;
    localparam int FFT_LOG2N    = 10;
    localparam int IDX_W        = FFT_LOG2N;
    localparam int BFLY_W       = FFT_LOG2N - 1;
    localparam int STAGE_W      = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        UNLOAD,
        DONE
    } fft_state_t;

endpackage

// File: rtl/fft_stage_counter.sv
// fft_stage_counter: butterfly/stage index pair for address_generator.
//   clk, rst_n : clock, async active-low reset
//   en_i       : advance one butterfly this cycle
//   cycle_o    : butterfly index within the stage, 0..N/2-1
//   stage_o    : stage index, 0..LOG2N-1
//   last_o     : current position is the last butterfly of the last stage
// On the last butterfly an enabled step returns both counters to 0, so the
// pair is already cleared for the next transform.
module fft_stage_counter
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    output logic [LOG2N-2:0]   cycle_o,
    output logic [STAGE_W-1:0] stage_o,
    output logic               last_o
);

    localparam logic [LOG2N-2:0]   CYC_LAST = '1;
    localparam logic [STAGE_W-1:0] STG_LAST = STAGE_W'(LOG2N - 1);

    logic [LOG2N-2:0]   cycle_q, cycle_d;
    logic [STAGE_W-1:0] stage_q, stage_d;

    assign last_o  = (cycle_q == CYC_LAST) && (stage_q == STG_LAST);
    assign cycle_o = cycle_q;
    assign stage_o = stage_q;

    always_comb begin
        cycle_d = cycle_q;
        stage_d = stage_q;
        if (en_i) begin
            if (last_o) begin
                cycle_d = '0;
                stage_d = '0;
            end else begin
                cycle_d = cycle_q + 1'b1;
                if (cycle_q == CYC_LAST) begin
                    stage_d = stage_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            stage_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            stage_q <= stage_d;
        end
    end

endmodule

// File: rtl/fft_controller.sv
// fft_controller: sequencing FSM for the radix-2 FFT datapath.
// Streams samples into fft_ram, steps address_generator through every
// stage/butterfly with write-back enabled, and optionally streams the result.
// Optional feature macro: FFT_UNLOAD_EN (adds the UNLOAD state and outValid).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   start                 : begin a transform (IDLE only)
//   inValid / inReady     : sample input handshake
//   externalLoad          : fft_ram port-A write strobe for the input sample
//   extSel                : port-A index taken from externalIndexA
//   externalIndexA        : external RAM index during load/unload
//   load                  : butterfly write-back enable
//   stageCount/cycleCount : stage and butterfly index to address_generator
//   outValid / outReady   : result output handshake
//   busy, done            : not-idle flag, completion pulse
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// LOAD   | accepting N_POINTS samples into fft_ram
// CALC   | one butterfly per cycle over all stages
// UNLOAD | streaming results out in index order
// DONE   | one-cycle completion pulse
module fft_controller
    import fft_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int LOG2N    = FFT_LOG2N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             inValid,
    output logic             inReady,
    output logic             externalLoad,
    output logic             extSel,
    output logic [LOG2N-1:0] externalIndexA,
    output logic             load,
    output logic [4:0]       stageCount,
    output logic [LOG2N-2:0] cycleCount,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy,
    output logic             done
);

    localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N_POINTS - 1);

    fft_state_t       state_q, state_d;
    // Shared by LOAD and UNLOAD; both exit with the counter wrapped to 0.
    logic [LOG2N-1:0] idx_q, idx_d;
    logic             calc_last;

    fft_stage_counter #(.LOG2N(LOG2N)) u_stage_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == CALC),
        .cycle_o (cycleCount),
        .stage_o (stageCount),
        .last_o  (calc_last)
    );

`ifndef FFT_UNLOAD_EN
    logic unused_out_ready;
    assign unused_out_ready = outReady;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (inValid) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = CALC;
                end
            end
            CALC: begin
`ifdef FFT_UNLOAD_EN
                if (calc_last) state_d = UNLOAD;
`else
                if (calc_last) state_d = DONE;
`endif
            end
`ifdef FFT_UNLOAD_EN
            UNLOAD: begin
                if (outReady) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inReady        = 1'b0;
        externalLoad   = 1'b0;
        extSel         = 1'b0;
        externalIndexA = '0;
        load           = 1'b0;
        outValid       = 1'b0;
        busy           = (state_q != IDLE);
        done           = 1'b0;
        case (state_q)
            LOAD: begin
                inReady        = 1'b1;
                externalLoad   = inValid;
                extSel         = 1'b1;
                externalIndexA = idx_q;
            end
            CALC: load = 1'b1;
`ifdef FFT_UNLOAD_EN
            UNLOAD: begin
                extSel         = 1'b1;
                externalIndexA = idx_q;
                outValid       = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fft_controller.sv
// tb_fft_controller: self-checking bench for fft_controller.
// Build with +define+FFT_UNLOAD_EN to exercise the unload path as well.
module tb_fft_controller;
    import fft_pkg::*;

    localparam int NP     = FFT_N_POINTS;
    localparam int HALF   = NP / 2;
    localparam int STAGES = FFT_LOG2N;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 inValid = 1'b0;
    logic                 outReady = 1'b0;
    logic                 inReady, externalLoad, extSel, load, outValid, busy, done;
    logic [IDX_W-1:0]     externalIndexA;
    logic [4:0]           stageCount;
    logic [BFLY_W-1:0]    cycleCount;

    int errors = 0;
    int checks = 0;

    fft_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .inValid        (inValid),
        .inReady        (inReady),
        .externalLoad   (externalLoad),
        .extSel         (extSel),
        .externalIndexA (externalIndexA),
        .load           (load),
        .stageCount     (stageCount),
        .cycleCount     (cycleCount),
        .outValid       (outValid),
        .outReady       (outReady),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef logic [7+IDX_W+5+BFLY_W-1:0] ovec_t;

    // {busy,inReady,extSel,externalLoad,load,outValid,done,index,stage,cycle}
    function automatic ovec_t pack(bit b, bit ir, bit es, bit el, bit ld, bit ov, bit dn,
                                   int idx, int st, int cy);
        return {b, ir, es, el, ld, ov, dn, IDX_W'(idx), 5'(st), BFLY_W'(cy)};
    endfunction

    function automatic ovec_t actual();
        return {busy, inReady, extSel, externalLoad, load, outValid, done,
                externalIndexA, stageCount, cycleCount};
    endfunction

    task automatic chk(string tag, int step, ovec_t exp);
        ovec_t act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d got=%h want=%h (busy,inRdy,extSel,extLd,load,outV,done,idx,stage,cyc)",
                     tag, step, act, exp);
        end
    endtask

    task automatic timeout(string tag);
        checks++;
        errors++;
        $display("FAIL %s bound expired", tag);
    endtask

    typedef struct {
        bit    rst;
        bit    st;
        bit    iv;
        bit    ordy;
        ovec_t exp;
    } vec_t;

    vec_t tbl[9];

    // One transform. mode 0: handshakes always ready; 1: patterned gaps;
    // 2: random gaps. abort_k >= 0 resets the DUT at that CALC cycle.
    task automatic run(int mode, int abort_k);
        int acc, guard, ucnt, low;
        @(negedge clk);
        start = 1'b1; inValid = 1'($urandom_range(0, 1)); outReady = 1'($urandom_range(0, 1));
        #1 chk("idle_start", 0, pack(0,0,0,0,0,0,0,0,0,0));

        acc = 0; guard = 0;
        while (acc < NP && guard < 8000) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            case (mode)
                0:       inValid = 1'b1;
                1:       inValid = guard[0];
                default: inValid = 1'($urandom_range(0, 1));
            endcase
            outReady = 1'($urandom_range(0, 1));
            #1 chk("load", acc, pack(1,1,1,inValid,0,0,0,acc,0,0));
            if (inValid) acc++;
            guard++;
        end
        if (acc < NP) timeout("load_accepts");

        for (int k = 0; k < STAGES * HALF; k++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); inValid = 1'($urandom_range(0, 1));
            outReady = 1'($urandom_range(0, 1));
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1 chk("reset_mid_calc", k, pack(0,0,0,0,0,0,0,0,0,0));
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk); start = 1'b1; inValid = 1'b1;
                    #1 chk("in_reset", r, pack(0,0,0,0,0,0,0,0,0,0));
                end
                @(negedge clk); rst_n = 1'b1; start = 1'b0;
                #1 chk("reset_release", 0, pack(0,0,0,0,0,0,0,0,0,0));
                @(negedge clk);
                #1 chk("stay_idle", 0, pack(0,0,0,0,0,0,0,0,0,0));
                return;
            end
            #1 chk("calc", k, pack(1,0,0,0,1,0,0,0,k / HALF,k % HALF));
        end

`ifdef FFT_UNLOAD_EN
        ucnt = 0; guard = 0; low = 0;
        while (ucnt < NP && guard < 8000) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1)); inValid = 1'($urandom_range(0, 1));
            case (mode)
                0: outReady = 1'b1;
                1: begin
                    if (ucnt == 500 && low < 5) begin
                        outReady = 1'b0;
                        low++;
                    end else begin
                        outReady = 1'b1;
                    end
                end
                default: outReady = 1'($urandom_range(0, 1));
            endcase
            #1 chk("unload", ucnt, pack(1,0,1,0,0,1,0,ucnt,0,0));
            if (outReady) ucnt++;
            guard++;
        end
        if (ucnt < NP) timeout("unload_consumes");
`else
        ucnt = 0; low = 0;
`endif

        @(negedge clk);
        start = 1'b0; inValid = 1'($urandom_range(0, 1)); outReady = 1'($urandom_range(0, 1));
        #1 chk("done_pulse", ucnt + low, pack(1,0,0,0,0,0,1,0,0,0));
        @(negedge clk);
        #1 chk("idle_after", 0, pack(0,0,0,0,0,0,0,0,0,0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst st iv or  expected outputs
        tbl[0] = '{0, 0, 0, 0, pack(0,0,0,0,0,0,0,0,0,0)};
        tbl[1] = '{1, 0, 0, 0, pack(0,0,0,0,0,0,0,0,0,0)};
        tbl[2] = '{1, 1, 1, 1, pack(0,0,0,0,0,0,0,0,0,0)};
        tbl[3] = '{1, 0, 1, 0, pack(1,1,1,1,0,0,0,0,0,0)};
        tbl[4] = '{1, 0, 0, 1, pack(1,1,1,0,0,0,0,1,0,0)};
        tbl[5] = '{1, 1, 1, 0, pack(1,1,1,1,0,0,0,1,0,0)};
        tbl[6] = '{1, 0, 1, 0, pack(1,1,1,1,0,0,0,2,0,0)};
        tbl[7] = '{0, 0, 1, 1, pack(0,0,0,0,0,0,0,0,0,0)};
        tbl[8] = '{1, 0, 1, 0, pack(0,0,0,0,0,0,0,0,0,0)};

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst; start = tbl[i].st;
            inValid = tbl[i].iv; outReady = tbl[i].ordy;
            #1 chk("table", i, tbl[i].exp);
        end
        @(negedge clk);
        inValid = 1'b0; start = 1'b0;
        #1 chk("idle_settle", 0, pack(0,0,0,0,0,0,0,0,0,0));

        run(0, -1);
        run(1, -1);
        run(2, 4 * HALF + 37);
        run(0, -1);
        run(2, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
